fetch_unit: RTL
===============

Name: fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of InstructionMemory. It owns the program counter, drives the memory word address and captures the returned instruction words. It presents them to decode through a valid/ready interface with a 2-entry buffer, so that backpressure never drops an in-flight read. It supports PC redirect (branch/jump) with a flush, and raises a sticky fault on out-of-range fetch.

Parameters:
ADDR_W, 32, width of PC and memory address (word address)
DATA_W, 32, instruction width
IMEM_DEPTH, 128, number of valid instruction words; legal PCs are 0..IMEM_DEPTH-1
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  rising-edge clock shared with InstructionMemory
rsta  in  1  asynchronous active-high reset
imem_addr  out  ADDR_W  word address to InstructionMemory addra; always equals the PC register
imem_data  in  DATA_W  InstructionMemory douta; valid one cycle after the address is sampled
redirect_valid  in  1  load new PC this cycle and flush
redirect_pc  in  ADDR_W  target word address
out_valid  out  1  out_instr/out_pc hold a fetched instruction
out_ready  in  1  decode accepts the head entry when out_valid=1
out_instr  out  DATA_W  instruction word at buffer head
out_pc  out  ADDR_W  word address of out_instr
fault  out  1  sticky: PC reached IMEM_DEPTH or beyond

Behaviour:
- Reset (async, immediate on rsta=1): pc=RESET_PC, imem_addr=RESET_PC, in-flight flag=0, buffer empty, out_valid=0, out_instr=0, out_pc=0, fault=0. Mid-operation reset discards everything at once.
- Memory model: synchronous read, 1-cycle latency. The address sampled at edge N produces data on imem_data after edge N, and the fetch unit captures it at edge N+1.
- pop = out_valid & out_ready.
- issue = !redirect_valid & !fault & (pc < IMEM_DEPTH) & (count + inflight - pop < 2), where count is the buffer occupancy (0..2) and inflight is a 1-bit flag.
- On issue: inflight<=1, inflight_pc<=pc, pc<=pc+1. Otherwise inflight<=0.
- If inflight=1 and there is no redirect, push {imem_data, inflight_pc} into the buffer at the edge. Push and pop may occur on the same edge; count is then unchanged.
- The buffer is FIFO-ordered. The head drives out_instr/out_pc. out_valid = (count != 0). Outputs are held stable while out_valid=1 and out_ready=0.
- Sustained throughput is 1 instruction/cycle with out_ready=1. First out_valid appears at the 2nd rising edge after rsta deasserts (edge 1 issues, edge 2 captures).
- Redirect (highest priority):
  - At the edge: pc<=redirect_pc, buffer cleared, inflight<=0 (squashed), fault<=0.
  - Pop on the same cycle is ignored; no push occurs.
  - The next cycle issues redirect_pc, so the first redirected instruction is valid 2 edges after the redirect edge.
- Out-of-range: when pc >= IMEM_DEPTH and no redirect, set fault<=1 and stop issuing.
  - Instructions already in the buffer or in flight still drain normally.
  - fault stays high until redirect or reset.
  - A redirect to an out-of-range target sets fault on the following cycle.
- PC arithmetic is ADDR_W wide unsigned. pc+1 is not wrapped modulo IMEM_DEPTH; overflow past IMEM_DEPTH-1 is caught by the fault rule.
- No combinational path from out_ready to imem_addr (imem_addr is registered).

Decomposition:
- Shared package fetch_pkg: ADDR_W, DATA_W, IMEM_DEPTH, RESET_PC constants, and a fetch_entry struct {instr, pc}.
- One sub-module, fetch_buffer: 2-entry synchronous FIFO with push, pop, flush, count, and head outputs, reset by rsta. The PC, issue logic and fault logic stay in fetch_unit.

Test Plan:
1. Memory loaded with IMem[k]=32'h1000_0000+k; out_ready=1 after reset -> out_valid from edge 2, then out_pc 0,1,2,... with out_instr 1000_0000,1000_0001,... on consecutive cycles, no gaps.
2. out_ready=0 for 5 cycles after the first out_valid -> count stays 2, pc stops at 2, out_pc held at 0. On release, 0,1,2,3 are delivered in order with no loss or duplicate.
3. Redirect to 40 while entries 5,6 are buffered and 7 is in flight -> 5,6,7 never appear. Next delivered out_pc=40 with instr 1000_0028, appearing 2 edges after the redirect.
4. Redirect to 126, out_ready=1 -> pc 126,127 delivered, then fault=1 and out_valid drops. A later redirect to 0 clears fault and fetching resumes at 0.
5. Redirect asserted in the same cycle as pop with out_valid=1 -> buffer flushed and no stale entry. Next delivered entry is the redirect target.
6. rsta pulsed mid-stream (asynchronously, between edges) -> out_valid=0, fault=0, imem_addr=0 immediately. After release, fetch restarts at pc 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared widths, limits and the buffered fetch entry layout for the fetch stage.
package fetch_pkg;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int IMEM_DEPTH = 128;

  localparam logic [ADDR_W-1:0] RESET_PC   = '0;
  localparam logic [ADDR_W-1:0] IMEM_LIMIT = ADDR_W'(IMEM_DEPTH);

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] pc;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO between the fetch stage and decode; push visible at head the next cycle.
// No internal backpressure: the issue logic upstream guarantees a push never lands on a full buffer.
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rsta,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_dat,
  input  logic               pop,
  input  logic               flush,
  output logic [1:0]         count,
  output logic [ENTRY_W-1:0] head_dat
);

  fetch_entry_t mem_q [2];
  fetch_entry_t mem_d [2];
  logic         rd_ptr_q, rd_ptr_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         pop_ok, push_ok;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    pop_ok   = pop && (count_q != 2'd0);
    push_ok  = push && ((count_q != 2'd2) || pop_ok);
    if (flush) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = fetch_entry_t'(push_dat);
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

  always_ff @(posedge clk or posedge rsta) begin
    if (rsta) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count    = count_q;
  assign head_dat = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// PC owner and fetch front-end: 1-cycle memory read, first instruction valid 2 edges after issue.
// Stalls issue when buffered + in-flight entries would exceed 2, so a read is never dropped.
module fetch_unit
  import fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rsta,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic              fault
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic              inflight_q, inflight_d;
  logic              fault_q, fault_d;

  logic [1:0]   count;
  logic [2:0]   occ;
  logic         pop, push, issue, in_range;
  fetch_entry_t push_ent, head_ent;

  always_comb begin
    in_range = pc_q < IMEM_LIMIT;
    pop      = out_valid && out_ready;
    // Occupancy after this edge if we do not issue; issuing must keep it below 2.
    occ      = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
    issue    = !redirect_valid && !fault_q && in_range && (occ < 3'd2);
    push     = inflight_q && !redirect_valid;
    push_ent = '{instr: imem_data, pc: inflight_pc_q};

    pc_d          = pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    fault_d       = fault_q;

    if (redirect_valid) begin
      pc_d       = redirect_pc;
      inflight_d = 1'b0;
      fault_d    = 1'b0;
    end else begin
      if (!in_range) begin
        fault_d = 1'b1;
      end
      if (issue) begin
        pc_d          = pc_q + 1'b1;
        inflight_pc_d = pc_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rsta) begin
    if (rsta) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      fault_q       <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      fault_q       <= fault_d;
    end
  end

  fetch_buffer u_buf (
    .clk      (clk),
    .rsta     (rsta),
    .push     (push),
    .push_dat (push_ent),
    .pop      (pop && !redirect_valid),
    .flush    (redirect_valid),
    .count    (count),
    .head_dat (head_ent)
  );

  assign imem_addr = pc_q;
  assign out_valid = (count != 2'd0);
  assign out_instr = head_ent.instr;
  assign out_pc    = head_ent.pc;
  assign fault     = fault_q;

endmodule
